// File: rtl/line_cmd_decoder_pkg.sv
// line_cmd_decoder_pkg: command bytes, ASCII bounds and FSM states shared by the line command decoder
package line_cmd_decoder_pkg;
  localparam logic [7:0] CMD_LINE = 8'h4C;
  localparam logic [7:0] CMD_BRIGHT = 8'h42;
  localparam logic [7:0] CMD_RGB = 8'h52;
  localparam logic [7:0] ASCII_0 = 8'h30;
  localparam logic [7:0] ASCII_9 = 8'h39;
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ROW_HI  = 3'd1,
    ROW_LO  = 3'd2,
    PAYLOAD = 3'd3,
    ARG_B   = 3'd4,
    ARG_R   = 3'd5
  } state_t;
  function automatic logic is_digit(input logic [7:0] b);
    return b >= ASCII_0 && b <= ASCII_9;
  endfunction
endpackage

// File: rtl/line_cmd_decoder_timeout.sv
// line_cmd_decoder_timeout: idle-clock watchdog, restarted by start, counting while running
module line_cmd_decoder_timeout #(
  parameter int WIDTH = 16
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             start,
  input  logic             running,
  input  logic [WIDTH-1:0] value,
  output logic             expired
);
  logic [WIDTH-1:0] count_q;
  // count idle clocks; any new byte or leaving the running state restarts from zero
  always_ff @(posedge clk_in)
    count_q <= (reset || start || !running) ? '0 : count_q + 1'b1;
  // fires on the value-th consecutive idle clock, unless a byte lands on that same clock
  assign expired = running && !start && count_q == value - 1'b1;
endmodule

// File: rtl/line_cmd_decoder.sv
// line_cmd_decoder: parses UART bytes into framebuffer row writes and enable settings
module line_cmd_decoder
  import line_cmd_decoder_pkg::*;
#(
  parameter int ROWS = 32,
  parameter int BYTES_PER_ROW = 128,
  parameter int ADDR_WIDTH = 12,
  parameter int TIMEOUT_WIDTH = 16,
  parameter logic [TIMEOUT_WIDTH-1:0] TIMEOUT_TICKS = 16'd50000
) (
  input  logic                  clk_in,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [7:0]            ram_data_out,
  output logic                  ram_write_enable,
  output logic                  ram_clk_enable,
  output logic [2:0]            rgb_enable,
  output logic [5:0]            brightness_enable,
  output logic                  busy,
  output logic                  cmd_error,
  output logic [7:0]            num_commands_processed
);
  localparam int ROW_W = $clog2(ROWS);
  localparam int IDX_W = $clog2(BYTES_PER_ROW);
  state_t state_q, state_d;
  logic [6:0] tens_q, row_sum;
  logic [ROW_W-1:0] row_q;
  logic [IDX_W-1:0] idx_q;
  logic digit_ok, row_ok, last_byte, expired, wr, err, done;
  assign digit_ok = is_digit(rx_data);
  assign row_sum = tens_q + {3'b0, rx_data[3:0]};
  assign row_ok = digit_ok && int'(row_sum) < ROWS;
  assign last_byte = int'(idx_q) == BYTES_PER_ROW - 1;
  assign busy = state_q != IDLE;
  assign ram_clk_enable = ram_write_enable;
  line_cmd_decoder_timeout #(.WIDTH(TIMEOUT_WIDTH)) u_timeout (
    .clk_in  (clk_in),
    .reset   (reset),
    .start   (rx_valid),
    .running (busy),
    .value   (TIMEOUT_TICKS),
    .expired (expired)
  );
  // state register
  always_ff @(posedge clk_in)
    state_q <= reset ? IDLE : state_d;
  // next state plus write/error/completion strobes; a byte always beats a coincident timeout
  always_comb begin
    state_d = state_q;
    wr = 1'b0;
    err = 1'b0;
    done = 1'b0;
    if (rx_valid) begin
      case (state_q)
        IDLE: state_d = rx_data == CMD_LINE ? ROW_HI : rx_data == CMD_BRIGHT ? ARG_B :
                        rx_data == CMD_RGB ? ARG_R : IDLE;
        ROW_HI: begin
          state_d = digit_ok ? ROW_LO : IDLE;
          err = !digit_ok;
        end
        ROW_LO: begin
          state_d = row_ok ? PAYLOAD : IDLE;
          err = !row_ok;
        end
        PAYLOAD: begin
          wr = 1'b1;
          done = last_byte;
          state_d = last_byte ? IDLE : PAYLOAD;
        end
        ARG_B, ARG_R: begin
          done = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end else if (expired) begin
      state_d = IDLE;
      err = 1'b1;
    end
  end
  // datapath: row capture, registered RAM write port, settings and command counter
  always_ff @(posedge clk_in) begin
    if (reset) begin
      tens_q <= '0;
      row_q <= '0;
      idx_q <= '0;
      ram_address <= '0;
      ram_data_out <= '0;
      ram_write_enable <= 1'b0;
      cmd_error <= 1'b0;
      num_commands_processed <= '0;
      rgb_enable <= 3'b111;
      brightness_enable <= 6'b111111;
    end else begin
      ram_write_enable <= wr;
      cmd_error <= err;
      if (done) num_commands_processed <= num_commands_processed + 1'b1;
      if (wr) begin
        ram_address <= ADDR_WIDTH'({row_q, idx_q});
        ram_data_out <= rx_data;
        idx_q <= idx_q + 1'b1;
      end
      if (rx_valid && state_q == ROW_HI) tens_q <= {3'b0, rx_data[3:0]} * 7'd10;
      if (rx_valid && state_q == ROW_LO && row_ok) begin
        row_q <= row_sum[ROW_W-1:0];
        idx_q <= '0;
      end
      if (rx_valid && state_q == ARG_B) brightness_enable <= rx_data[5:0];
      if (rx_valid && state_q == ARG_R) rgb_enable <= rx_data[2:0];
    end
  end
endmodule
